// File: rtl/tof_irq_stamp_core.sv
// Timestamps edges on an asynchronous ToF interrupt pin into a FIFO that sits
// behind an MMIO slot. An interrupt is raised while any timestamp is queued.
module tof_irq_stamp_core #(
    parameter int FIFO_DEPTH_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    output logic [31:0] rd_data,
    input  logic [31:0] wr_data,
    input  logic        tof_irq,
    output logic        irq
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam logic [FIFO_DEPTH_BIT:0] DEPTH_CNT = (FIFO_DEPTH_BIT + 1)'(DEPTH);

    logic                      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic                      evt_q, evt_d;
    logic [31:0]               ts_q, ts_d, evt_cnt_q, evt_cnt_d;
    logic [FIFO_DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BIT:0]   count_q, count_d;
    logic                      ovf_q, ovf_d, en_q, en_d, edge_sel_q, edge_sel_d;
    logic                      irq_en_q, irq_en_d, irq_q, irq_d;
    logic [31:0]               mem_q [DEPTH];

    logic ctrl_wr, pop_wr, clr_ovf, flush, rise, fall, qual;
    logic empty, full, do_pop, do_push, ovf_set, mem_we;
    logic unused_inputs;

    assign unused_inputs = ^{read, wr_data[31:5]};

    always_comb begin
        ctrl_wr = cs & write & (addr == 5'd2);
        pop_wr  = cs & write & (addr == 5'd3);
        clr_ovf = ctrl_wr & wr_data[3];
        flush   = ctrl_wr & wr_data[4];

        // The edge detector runs regardless of enable so re-enabling never
        // sees a stale level difference.
        rise = sync2_q & ~prev_q;
        fall = ~sync2_q & prev_q;
        qual = en_q & (edge_sel_q ? rise : fall);

        empty   = (count_q == '0);
        full    = (count_q == DEPTH_CNT);
        do_pop  = pop_wr & ~empty;
        do_push = evt_q & (~full | do_pop);
        ovf_set = evt_q & full & ~do_pop;
        mem_we  = do_push & ~flush;

        sync1_d    = tof_irq;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        evt_d      = qual;
        ts_d       = ts_q + 32'd1;
        evt_cnt_d  = evt_cnt_q + {31'd0, evt_q};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        en_d       = en_q;
        edge_sel_d = edge_sel_q;
        irq_en_d   = irq_en_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (ovf_set)      ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;

        if (ctrl_wr) begin
            en_d       = wr_data[0];
            edge_sel_d = wr_data[1];
            irq_en_d   = wr_data[2];
        end

        // Registered so the pin never sees a combinational glitch.
        irq_d = irq_en_d & (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            evt_q      <= 1'b0;
            ts_q       <= '0;
            evt_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            en_q       <= 1'b0;
            edge_sel_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            evt_q      <= evt_d;
            ts_q       <= ts_d;
            evt_cnt_q  <= evt_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            edge_sel_q <= edge_sel_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= ts_q;
    end

    always_comb begin
        case (addr)
            5'd0:    rd_data = empty ? 32'd0 : mem_q[rd_ptr_q];
            5'd1:    rd_data = {16'd0, 8'(count_q), 5'd0, ovf_q, full, empty};
            5'd2:    rd_data = {29'd0, irq_en_q, edge_sel_q, en_q};
            5'd3:    rd_data = ts_q;
            5'd4:    rd_data = evt_cnt_q;
            default: rd_data = 32'd0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_tof_irq_stamp_core.sv
// Directed bench for tof_irq_stamp_core: reset, single event, overflow,
// full push+pop, flush, polarity/enable, counter wrap and irq.
module tb_tof_irq_stamp_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] rd_data;
    logic [31:0] wr_data = '0;
    logic        tof_irq = 1'b1;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    int          n_evt = 0;
    logic [31:0] ofs = '0;
    logic [31:0] tb_cyc;
    logic [31:0] exp_q [$];
    logic [31:0] v, c, e;

    tof_irq_stamp_core #(.FIFO_DEPTH_BIT(4)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .rd_data(rd_data), .wr_data(wr_data),
        .tof_irq(tof_irq), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference cycle count: equals the DUT timestamp once ofs is added.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wr_data = '0;
        tick(2);
        reset = 1'b1;
        ofs = '0; n_evt = 0;
        exp_q.delete();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    // One falling pulse; returns when the entry is readable.
    task automatic fall_evt();
        exp_q.push_back(tb_cyc + ofs + 32'd3);
        tof_irq = 1'b0;
        tick(2);
        tof_irq = 1'b1;
        tick(2);
        n_evt++;
    endtask

    task automatic test_reset();
        tof_irq = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        rd(5'd3, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL rst_ts_in_reset got=%h exp=%h", v, 32'd0); end
        do_reset();
        rd(5'd1, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL rst_status got=%h exp=%h", v, 32'h1); end
        rd(5'd0, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL rst_head got=%h exp=%h", v, 32'd0); end
        rd(5'd2, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL rst_ctrl got=%h exp=%h", v, 32'd0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        tick(6);
        rd(5'd4, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL rst_evt_cnt got=%h exp=%h", v, 32'd0); end
    endtask

    task automatic test_single_event();
        wr(5'd2, 32'h1);
        c = tb_cyc + ofs;
        tof_irq = 1'b0;
        tick(4);
        rd(5'd1, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL single_status got=%h exp=%h", v, 32'h100); end
        rd(5'd0, v); checks++;
        if (v !== c + 32'd3) begin failures++; $display("FAIL single_head got=%h exp=%h", v, c + 32'd3); end
        rd(5'd4, v); checks++;
        if (v !== 32'd1) begin failures++; $display("FAIL single_evt_cnt got=%h exp=%h", v, 32'd1); end
        e = tb_cyc + ofs;
        rd(5'd3, v); checks++;
        if (v !== e) begin failures++; $display("FAIL single_ts got=%h exp=%h", v, e); end
        rd(5'd0, v); checks++;
        if (v !== c + 32'd3) begin failures++; $display("FAIL single_head_nondestr got=%h exp=%h", v, c + 32'd3); end
        tof_irq = 1'b1;
        tick(3);
    endtask

    task automatic test_overflow();
        do_reset();
        tick(4);
        wr(5'd2, 32'h1);
        repeat (17) fall_evt();
        void'(exp_q.pop_back());
        rd(5'd1, v); checks++;
        if (v !== 32'h1006) begin failures++; $display("FAIL ovf_status got=%h exp=%h", v, 32'h1006); end
        rd(5'd4, v); checks++;
        if (v !== 32'd17) begin failures++; $display("FAIL ovf_evt_cnt got=%h exp=%h", v, 32'd17); end
        rd(5'd0, v); checks++;
        if (v !== exp_q[0]) begin failures++; $display("FAIL ovf_head got=%h exp=%h", v, exp_q[0]); end
        wr(5'd2, 32'h9);
        rd(5'd1, v); checks++;
        if (v !== 32'h1002) begin failures++; $display("FAIL clr_ovf_status got=%h exp=%h", v, 32'h1002); end
    endtask

    task automatic test_full_push_pop();
        c = tb_cyc + ofs;
        tof_irq = 1'b0;
        tick(3);
        wr(5'd3, 32'hDEAD_BEEF);
        void'(exp_q.pop_front());
        exp_q.push_back(c + 32'd3);
        n_evt++;
        tof_irq = 1'b1;
        rd(5'd1, v); checks++;
        if (v !== 32'h1002) begin failures++; $display("FAIL fullpp_status got=%h exp=%h", v, 32'h1002); end
        rd(5'd4, v); checks++;
        if (v !== n_evt) begin failures++; $display("FAIL fullpp_evt_cnt got=%h exp=%h", v, n_evt); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            rd(5'd0, v); checks++;
            if (v !== e) begin failures++; $display("FAIL drain_head[%0d] got=%h exp=%h", i, v, e); end
            wr(5'd3, 32'd0);
        end
        rd(5'd1, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL drain_status got=%h exp=%h", v, 32'h1); end
    endtask

    task automatic test_flush_with_event();
        fall_evt();
        rd(5'd1, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL flush_pre_status got=%h exp=%h", v, 32'h100); end
        tof_irq = 1'b0;
        tick(3);
        wr(5'd2, 32'h11);
        n_evt++;
        exp_q.delete();
        tof_irq = 1'b1;
        tick(2);
        rd(5'd1, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL flush_status got=%h exp=%h", v, 32'h1); end
        rd(5'd4, v); checks++;
        if (v !== n_evt) begin failures++; $display("FAIL flush_evt_cnt got=%h exp=%h", v, n_evt); end
        rd(5'd0, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL flush_head got=%h exp=%h", v, 32'd0); end
    endtask

    task automatic test_edge_enable();
        tof_irq = 1'b0;
        do_reset();
        tick(4);
        wr(5'd2, 32'h2);
        tof_irq = 1'b1;
        tick(6);
        wr(5'd2, 32'h3);
        tick(6);
        rd(5'd1, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL reenable_status got=%h exp=%h", v, 32'h1); end
        rd(5'd4, v); checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL reenable_evt_cnt got=%h exp=%h", v, 32'd0); end
        tof_irq = 1'b0;
        tick(6);
        rd(5'd1, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL rise_mode_fall_status got=%h exp=%h", v, 32'h1); end
        c = tb_cyc + ofs;
        tof_irq = 1'b1;
        tick(4);
        rd(5'd1, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL rise_status got=%h exp=%h", v, 32'h100); end
        rd(5'd0, v); checks++;
        if (v !== c + 32'd3) begin failures++; $display("FAIL rise_head got=%h exp=%h", v, c + 32'd3); end
        rd(5'd4, v); checks++;
        if (v !== 32'd1) begin failures++; $display("FAIL rise_evt_cnt got=%h exp=%h", v, 32'd1); end
    endtask

    task automatic test_wrap_irq();
        tof_irq = 1'b1;
        do_reset();
        tick(4);
        wr(5'd2, 32'h5);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_empty got=%b exp=0", irq); end
        force dut.ts_q = 32'hFFFF_FFFE;
        #1;
        release dut.ts_q;
        ofs = 32'hFFFF_FFFE - tb_cyc;
        tof_irq = 1'b0;
        tick(4);
        rd(5'd0, v); checks++;
        if (v !== 32'd1) begin failures++; $display("FAIL wrap_head got=%h exp=%h", v, 32'd1); end
        e = tb_cyc + ofs;
        rd(5'd3, v); checks++;
        if (v !== e) begin failures++; $display("FAIL wrap_ts got=%h exp=%h", v, e); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_pending got=%b exp=1", irq); end
        tof_irq = 1'b1;
        tick(2);
        wr(5'd3, 32'd0);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
        wr(5'd3, 32'd0);
        rd(5'd1, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL pop_empty_status got=%h exp=%h", v, 32'h1); end
        fall_evt();
        e = exp_q.pop_front();
        rd(5'd0, v); checks++;
        if (v !== e) begin failures++; $display("FAIL after_empty_pop_head got=%h exp=%h", v, e); end
        rd(5'd1, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL after_empty_pop_status got=%h exp=%h", v, 32'h100); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_repend got=%b exp=1", irq); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_overflow();
        test_full_push_pop();
        test_flush_with_event();
        test_edge_enable();
        test_wrap_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tof_irq_stamp_core.md
TOF_IRQ_STAMP_CORE -- requirements
Module: tof_irq_stamp_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_BIT, default 4, log2 of timestamp FIFO depth (16 entries).
REQ-002 SHALL have port clk, input, 1, system clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cs, input, 1, slot select from MMIO controller.
REQ-005 SHALL have port read, input, 1, slot read strobe.
REQ-006 SHALL have port write, input, 1, slot write strobe.
REQ-007 SHALL have port addr, input, 5, slot register address.
REQ-008 SHALL have port rd_data, output, 32, slot read data.
REQ-009 SHALL have port wr_data, input, 32, slot write data.
REQ-010 SHALL have port tof_irq, input, 1, asynchronous ToF sensor interrupt pin.
REQ-011 SHALL have port irq, output, 1, event-pending interrupt to processor.

Function
REQ-012 SHALL pass tof_irq through a 2-flop synchronizer, then a 1-flop edge detector (prev vs current synchronized value).
REQ-013 SHALL keep a 32-bit free-running timestamp counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0, independent of enable.
REQ-014 SHALL define a qualifying event as one detected edge of the polarity in ctrl.edge_sel (0 = falling, 1 = rising) while ctrl.en = 1.
REQ-015 SHALL push the counter value of the detection cycle into the FIFO on each qualifying event; entry visible at addr 0 on the 4th rising edge after the pin change meets setup.
REQ-016 SHALL increment a 32-bit wrapping event counter on every qualifying event, including dropped ones.
REQ-017 SHALL, on a qualifying event with FIFO full and no same-cycle pop, drop the timestamp and set sticky status.ovf.
REQ-018 SHALL, on simultaneous push and pop with FIFO full, perform both; count unchanged, ovf not set.
REQ-019 SHALL ignore pop when FIFO empty; pointers and count unchanged.
REQ-020 SHALL give flush priority over same-cycle push and pop: FIFO empty next cycle, the pushed timestamp lost, event counter still increments.
REQ-021 SHALL keep the edge detector running while ctrl.en = 0, so re-enabling creates no spurious event.
REQ-022 SHALL decode writes only when cs & write: addr 2 = ctrl (bit0 en, bit1 edge_sel, bit2 irq_en stored; bit3 clr_ovf, bit4 flush are one-cycle pulses, not stored); addr 3 = pop (data ignored); other addresses ignored.
REQ-023 SHALL drive rd_data combinationally from addr, not gated by read: 0 = FIFO head (0 when empty); 1 = status {16'b0, count[7:0], 5'b0, ovf, full, empty}; 2 = ctrl {29'b0, irq_en, edge_sel, en}; 3 = timestamp counter; 4 = event counter; others = 0.
REQ-024 SHALL make addr 0 reads non-destructive; only an addr 3 write advances the head.
REQ-025 SHALL drive irq = irq_en & ~empty from registered state, glitch-free.
REQ-026 SHALL clear ovf on clr_ovf; if an overflow occurs in the same cycle, ovf stays set.
REQ-027 SHALL let count range 0..2^FIFO_DEPTH_BIT, full when equal to depth, with pointer wrap on power-of-two boundary.

Reset
REQ-028 SHALL, while reset = 0, asynchronously clear counters, FIFO pointers, count, ovf, ctrl, synchronizer and edge flops to 0.
REQ-029 SHALL produce after reset: irq = 0, status read 0x0000_0001, addr 0 read 0.
REQ-030 SHALL discard all queued timestamps and any in-flight synchronizer edge on reset mid-operation; no event logged from reset release alone.

Verification
REQ-031 SHALL cover single event: ctrl = 0x1, tof_irq 1->0 -> one entry, status 0x0000_0100, addr 0 read equals timestamp of detection cycle, event counter 1.
REQ-032 SHALL cover overflow: 17 falling edges, no pops -> count 16, ovf 1, status 0x0000_1006, event counter 17; clr_ovf -> status 0x0000_1002.
REQ-033 SHALL cover full push+pop: FIFO full, pop write coincident with detection -> count stays 16, ovf 0, head advances by one.
REQ-034 SHALL cover flush with event: flush pulse in detection cycle -> status 0x0000_0001, event counter +1.
REQ-035 SHALL cover edge polarity and enable: edge_sel = 1, en = 0 during a rise, then en = 1 with pin static high -> no entry; next rise -> one entry.
REQ-036 SHALL cover wrap and irq: preset counter near 0xFFFF_FFFF by long run or force, event after wrap -> small timestamp; irq_en = 1 -> irq = 1 while non-empty, 0 after final pop.
